// File: rtl/spi_flash_reader.sv
// SPI mode-0 fast-read responder for the sr_* read-request interface.
// Optional build macro SPI_FLASH_READER_WAKEUP_EN sends a 0xAB wake-up command after reset.
`timescale 1ns/1ps
module spi_flash_reader #(
  parameter int         HALF_PERIOD  = 1,
  parameter logic [7:0] CMD_READ     = 8'h0B,
  parameter int         DUMMY_CYCLES = 8,
  parameter int         CS_IDLE      = 2,
  parameter int         WAKE_WAIT    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] sr_addr,
  input  logic [15:0] sr_len,
  input  logic        sr_go,
  output logic        sr_rdy,
  output logic [7:0]  sr_data,
  output logic        sr_valid,
  output logic        spi_cs_n,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int HP_W  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int CNT_W = $clog2(WAKE_WAIT + CS_IDLE + 2);
  localparam logic [HP_W-1:0]  HP_LAST  = HP_W'(HALF_PERIOD - 1);
  localparam logic [7:0]       DUM_LAST = 8'(DUMMY_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_IDLE - 1);
`ifdef SPI_FLASH_READER_WAKEUP_EN
  localparam logic [7:0]       WAKE_CMD  = 8'hAB;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAKE_WAIT - 1);
`endif

  typedef enum logic [3:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_STOP, ST_GAP,
    ST_WAKE, ST_WCMD, ST_WSTOP, ST_WWAIT
  } state_t;

  state_t           state_r;
  logic [HP_W-1:0]  hp_cnt_r;
  logic [7:0]       bit_cnt_r;
  logic [CNT_W-1:0] cnt_r;
  logic [30:0]      tx_r;
  logic [6:0]       rx_r;
  logic [16:0]      byte_left_r;
  logic             shifting_s;
  logic             tick_s;
  logic             fall_s;
  logic             sample_s;

  // SCK phase decode: fall_s ends a bit (mosi update point), sample_s is the first clk of the high phase
  always_comb begin
    shifting_s = 1'b0;
    case (state_r)
      ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_WCMD: shifting_s = 1'b1;
      default:                                     shifting_s = 1'b0;
    endcase
    tick_s   = (hp_cnt_r == HP_LAST);
    fall_s   = shifting_s && spi_clk && tick_s;
    sample_s = (state_r == ST_DATA) && spi_clk && (hp_cnt_r == '0);
  end

  // Transaction FSM with SCK generation and byte assembly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef SPI_FLASH_READER_WAKEUP_EN
      state_r     <= ST_WAKE;
`else
      state_r     <= ST_IDLE;
`endif
      hp_cnt_r    <= '0;
      bit_cnt_r   <= 8'd0;
      cnt_r       <= '0;
      tx_r        <= 31'd0;
      rx_r        <= 7'd0;
      byte_left_r <= 17'd0;
      sr_rdy      <= 1'b0;
      sr_data     <= 8'd0;
      sr_valid    <= 1'b0;
      spi_cs_n    <= 1'b1;
      spi_clk     <= 1'b0;
      spi_mosi    <= 1'b0;
    end else begin
      sr_valid <= 1'b0;
      if (shifting_s) begin
        hp_cnt_r <= tick_s ? '0 : hp_cnt_r + HP_W'(1);
        if (tick_s) begin
          spi_clk <= ~spi_clk;
        end
      end
      if (sample_s) begin
        rx_r <= {rx_r[5:0], spi_miso};
        if (bit_cnt_r == 8'd7) begin
          sr_data  <= {rx_r, spi_miso};
          sr_valid <= 1'b1;
        end
      end

      case (state_r)
        ST_IDLE: begin
          if (!sr_rdy) begin
            sr_rdy <= 1'b1;
          end else if (sr_go) begin
            sr_rdy      <= 1'b0;
            spi_cs_n    <= 1'b0;
            spi_mosi    <= CMD_READ[7];
            tx_r        <= {CMD_READ[6:0], sr_addr};
            byte_left_r <= {1'b0, sr_len} + 17'd1;
            bit_cnt_r   <= 8'd0;
            hp_cnt_r    <= '0;
            state_r     <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (fall_s) begin
            spi_mosi <= tx_r[30];
            tx_r     <= {tx_r[29:0], 1'b0};
            if (bit_cnt_r == 8'd7) begin
              bit_cnt_r <= 8'd0;
              state_r   <= ST_ADDR;
            end else begin
              bit_cnt_r <= bit_cnt_r + 8'd1;
            end
          end
        end
        ST_ADDR: begin
          if (fall_s) begin
            if (bit_cnt_r == 8'd23) begin
              spi_mosi  <= 1'b0;
              bit_cnt_r <= 8'd0;
              state_r   <= ST_DUMMY;
            end else begin
              spi_mosi  <= tx_r[30];
              tx_r      <= {tx_r[29:0], 1'b0};
              bit_cnt_r <= bit_cnt_r + 8'd1;
            end
          end
        end
        ST_DUMMY: begin
          if (fall_s) begin
            if (bit_cnt_r == DUM_LAST) begin
              bit_cnt_r <= 8'd0;
              state_r   <= ST_DATA;
            end else begin
              bit_cnt_r <= bit_cnt_r + 8'd1;
            end
          end
        end
        ST_DATA: begin
          if (fall_s) begin
            if (bit_cnt_r == 8'd7) begin
              bit_cnt_r <= 8'd0;
              if (byte_left_r == 17'd1) begin
                state_r <= ST_STOP;
              end else begin
                byte_left_r <= byte_left_r - 17'd1;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + 8'd1;
            end
          end
        end
        // SCK is already low here, so cs_n rises one clk after the last falling edge
        ST_STOP: begin
          spi_cs_n <= 1'b1;
          cnt_r    <= '0;
          state_r  <= ST_GAP;
        end
        ST_GAP: begin
          if (cnt_r == GAP_LAST) begin
            sr_rdy  <= 1'b1;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
`ifdef SPI_FLASH_READER_WAKEUP_EN
        ST_WAKE: begin
          spi_cs_n  <= 1'b0;
          spi_mosi  <= WAKE_CMD[7];
          tx_r      <= {WAKE_CMD[6:0], 24'h000000};
          bit_cnt_r <= 8'd0;
          hp_cnt_r  <= '0;
          state_r   <= ST_WCMD;
        end
        ST_WCMD: begin
          if (fall_s) begin
            if (bit_cnt_r == 8'd7) begin
              spi_mosi  <= 1'b0;
              bit_cnt_r <= 8'd0;
              state_r   <= ST_WSTOP;
            end else begin
              spi_mosi  <= tx_r[30];
              tx_r      <= {tx_r[29:0], 1'b0};
              bit_cnt_r <= bit_cnt_r + 8'd1;
            end
          end
        end
        ST_WSTOP: begin
          spi_cs_n <= 1'b1;
          cnt_r    <= '0;
          state_r  <= ST_WWAIT;
        end
        ST_WWAIT: begin
          if (cnt_r == WAIT_LAST) begin
            sr_rdy  <= 1'b1;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
`endif
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader with a behavioural SPI flash model on the bus.
`timescale 1ns/1ps
module tb_spi_flash_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] sr_addr;
  logic [15:0] sr_len;
  logic        sr_go;
  logic        sr_rdy;
  logic [7:0]  sr_data;
  logic        sr_valid;
  logic        spi_cs_n;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  spi_flash_reader dut (
    .clk      (clk),
    .rst      (rst),
    .sr_addr  (sr_addr),
    .sr_len   (sr_len),
    .sr_go    (sr_go),
    .sr_rdy   (sr_rdy),
    .sr_data  (sr_data),
    .sr_valid (sr_valid),
    .spi_cs_n (spi_cs_n),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Flash contents: two fixed bytes at 0x040000, a simple address hash elsewhere
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    if (a == 24'h040000) return 8'hA5;
    else if (a == 24'h040001) return 8'h3C;
    else return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic flash_bit(input logic [23:0] a, input int idx);
    logic [7:0] b;
    b = flash_byte(a + 24'(idx / 8));
    return b[7 - (idx % 8)];
  endfunction

  int          sck_cnt   = 0;
  logic [31:0] shreg     = 32'd0;
  int          mosi_bad  = 0;
  int          stray_sck = 0;

  // Flash model: cs_n fall restarts the frame, rising SCK captures cmd+addr
  always @(posedge spi_clk or negedge spi_cs_n) begin
    if (!spi_clk) begin
      sck_cnt <= 0;
      shreg   <= 32'd0;
    end else if (spi_cs_n) begin
      stray_sck <= stray_sck + 1;
    end else begin
      if (sck_cnt < 32) shreg <= {shreg[30:0], spi_mosi};
      else if (spi_mosi !== 1'b0) mosi_bad <= mosi_bad + 1;
      sck_cnt <= sck_cnt + 1;
    end
  end

  always @(negedge spi_clk) begin
    if (!spi_cs_n && sck_cnt >= 40) spi_miso <= flash_bit(shreg[23:0], sck_cnt - 40);
  end

  logic [7:0] rx_q[$];
  int         vcyc_q[$];
  int         fall_cyc = 0;
  int         rise_cyc = 0;
  int         frames   = 0;
  int         last_gap = 0;
  int         high_run = 0;
  logic       prev_cs  = 1'b1;

  // Bus monitor sampled on the falling clk edge
  always @(negedge clk) begin
    if (sr_valid === 1'b1) begin
      rx_q.push_back(sr_data);
      vcyc_q.push_back(cyc);
    end
    if (prev_cs && !spi_cs_n) begin
      fall_cyc <= cyc;
      frames   <= frames + 1;
      last_gap <= high_run;
    end
    if (!prev_cs && spi_cs_n) rise_cyc <= cyc;
    if (spi_cs_n) high_run <= (prev_cs ? high_run : 0) + 1;
    prev_cs <= spi_cs_n;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [23:0] a, input logic [15:0] l);
    int t;
    t = 0;
    while (sr_rdy !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("issue_rdy_wait", 32'(t < 2000), 32'd1);
    sr_addr = a;
    sr_len  = l;
    sr_go   = 1'b1;
    @(negedge clk);
    sr_go   = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int t;
    t = 0;
    while (!(sr_rdy === 1'b1 && spi_cs_n === 1'b1) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(t < budget), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int f0;
    int t;
    int bad;
    int held;

    rst = 1'b1; sr_go = 1'b0; sr_addr = 24'd0; sr_len = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_rdy",   32'(sr_rdy),   32'd0);
    check("rst_valid", 32'(sr_valid), 32'd0);
    check("rst_data",  32'(sr_data),  32'd0);
    check("rst_cs_n",  32'(spi_cs_n), 32'd1);
    check("rst_sck",   32'(spi_clk),  32'd0);
    check("rst_mosi",  32'(spi_mosi), 32'd0);
    rst = 1'b0;
`ifdef SPI_FLASH_READER_WAKEUP_EN
    @(negedge clk);
    check("wake_rdy_low", 32'(sr_rdy), 32'd0);
    wait_done(400, "wake_done");
    check("wake_opcode", 32'(shreg[7:0]), 32'h000000AB);
    check("wake_sck",    32'(sck_cnt), 32'd8);
    check("wake_wait",   32'((cyc - rise_cyc) >= 64), 32'd1);
`else
    @(negedge clk);
    check("rdy_after_reset", 32'(sr_rdy), 32'd1);
`endif

    // Two-byte read, with a stray request dropped in during the data phase
    base = rx_q.size(); f0 = frames;
    issue(24'h040000, 16'h0001);
    t = 0;
    while (rx_q.size() <= base && t < 300) begin @(negedge clk); t++; end
    check("t1_first_valid", 32'(t < 300), 32'd1);
    sr_addr = 24'h123456; sr_len = 16'h0005; sr_go = 1'b1;
    @(negedge clk);
    sr_go = 1'b0;
    wait_done(200, "t1_done");
    repeat (30) @(negedge clk);
    check("t1_cmd",     32'(shreg[31:24]), 32'h0000000B);
    check("t1_addr",    32'(shreg[23:0]),  32'h00040000);
    check("t1_count",   32'(rx_q.size() - base), 32'd2);
    check("t1_byte0",   32'(rx_q[base]),     32'h000000A5);
    check("t1_byte1",   32'(rx_q[base + 1]), 32'h0000003C);
    check("t1_latency", 32'((vcyc_q[base] - fall_cyc) >= 96 && (vcyc_q[base] - fall_cyc) <= 98), 32'd1);
    check("t1_sck",     32'(sck_cnt), 32'd56);
    check("t3_frames",  32'(frames - f0), 32'd1);

    // 128-byte read: data, spacing and a single continuous frame
    base = rx_q.size(); f0 = frames;
    issue(24'h041080, 16'h007F);
    wait_done(128 * 16 + 300, "t2_done");
    repeat (2) @(negedge clk);
    check("t2_count", 32'(rx_q.size() - base), 32'd128);
    bad = 0;
    for (int i = 0; i < 128 && base + i < rx_q.size(); i++)
      if (rx_q[base + i] !== flash_byte(24'h041080 + 24'(i))) bad++;
    check("t2_data_errors", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 1; i < 128 && base + i < vcyc_q.size(); i++)
      if (vcyc_q[base + i] - vcyc_q[base + i - 1] != 16) bad++;
    check("t2_spacing_errors", 32'(bad), 32'd0);
    check("t2_frames", 32'(frames - f0), 32'd1);
    check("t2_sck",    32'(sck_cnt), 32'd1064);
    check("mosi_zero_dummy_data", 32'(mosi_bad), 32'd0);
    check("no_stray_sck", 32'(stray_sck), 32'd0);

    // Reset in the middle of a long read, then a clean short read
    base = rx_q.size();
    issue(24'h041080, 16'h007F);
    t = 0;
    while (rx_q.size() - base < 40 && t < 1200) begin @(negedge clk); t++; end
    check("t4_reach_byte40", 32'(t < 1200), 32'd1);
    rst = 1'b1;
    #1;
    check("t4_cs_n",  32'(spi_cs_n), 32'd1);
    check("t4_valid", 32'(sr_valid), 32'd0);
    check("t4_sck",   32'(spi_clk),  32'd0);
    check("t4_rdy",   32'(sr_rdy),   32'd0);
    @(negedge clk);
    held = rx_q.size();
    rst = 1'b0;
    wait_done(400, "t4_recover");
    repeat (4) @(negedge clk);
    check("t4_dropped", 32'(rx_q.size()), 32'(held));
    base = rx_q.size();
    issue(24'h040000, 16'h0001);
    wait_done(300, "t4_done");
    repeat (2) @(negedge clk);
    check("t4_count", 32'(rx_q.size() - base), 32'd2);
    check("t4_byte0", 32'(rx_q[base]),     32'h000000A5);
    check("t4_byte1", 32'(rx_q[base + 1]), 32'h0000003C);

    // Back-to-back requests on the first sr_rdy
    base = rx_q.size(); f0 = frames;
    issue(24'h040000, 16'h0000);
    issue(24'h040100, 16'h0000);
    wait_done(300, "t5_done");
    repeat (2) @(negedge clk);
    check("t5_frames",  32'(frames - f0), 32'd2);
    check("t5_gap_min", 32'(last_gap >= 2), 32'd1);
    check("t5_count",   32'(rx_q.size() - base), 32'd2);
    check("t5_byte0",   32'(rx_q[base]), 32'h000000A5);
    check("t5_byte1",   32'(rx_q[base + 1]), 32'(flash_byte(24'h040100)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
